// File: rtl/btn_debounce_pkg.sv
// Shared types for the push-button conditioner: FSM state encoding and
// the parameter legality rule checked by the top-level assertions.
package btn_pkg;

    typedef enum logic [1:0] {
        S_LO   = 2'd0,
        CHK_HI = 2'd1,
        S_HI   = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    // The check window must be at least two cycles and shorter than the long-press window.
    function automatic bit params_legal(input int stable_cycles, input int long_cycles);
        return (stable_cycles >= 2) && (long_cycles > stable_cycles);
    endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Button pin and conditioned outputs. The master drives the raw pin;
// the slave (the debouncer) drives the clean level and strobes.
interface btn_debounce_if;

    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_long;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );

endinterface

// File: rtl/btn_debounce_sync_2ff.sv
// Two-flop synchroniser bringing the asynchronous button pin into clk.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign q = sync2_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronise, debounce with a stability counter,
// and emit a clean level plus press / release / long-press strobes.
//
// state  | meaning
// S_LO   | button settled released, counter idle
// CHK_HI | input went high, counting stable-high cycles
// S_HI   | button settled pressed, counter measures hold time for long-press
// CHK_LO | input went low, counting stable-low cycles (level still reports high)
module btn_debounce
    import btn_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int LONG_CYCLES   = 64,
    parameter int CNT_W         = $clog2(LONG_CYCLES + 1)
) (
    input logic            clk,
    input logic            rst_n,
    btn_debounce_if.slave  btn
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX    = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             sync2;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             long_q, long_d;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn.btn_in),
        .q     (sync2)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;
        case (state_q)
            S_LO: begin
                cnt_d = '0;
                if (sync2) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_HI: begin
                if (!sync2) begin
                    state_d = S_LO;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_HI;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HI: begin
                if (!sync2) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    long_d = (cnt_q == LONG_LAST);
                    // Saturating at LONG_CYCLES keeps long-press to one strobe per hold.
                    if (cnt_q != LONG_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            CHK_LO: begin
                if (sync2) begin
                    state_d = S_HI;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_LO;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LO;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == S_HI) || (state_d == CHK_LO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
        end
    end

    assign btn.btn_level   = level_q;
    assign btn.btn_press   = press_q;
    assign btn.btn_release = rel_q;
    assign btn.btn_long    = long_q;

    a_params_legal: assert property (@(posedge clk)
        params_legal(STABLE_CYCLES, LONG_CYCLES));
    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q <= LONG_MAX);
    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({press_q, rel_q, long_q}));

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce with STABLE_CYCLES=4, LONG_CYCLES=10.
// Stimulus pushes the expected strobe (kind, edge number); a negedge monitor pops and compares.
module tb_btn_debounce;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    btn_debounce_if bus ();

    btn_debounce #(
        .STABLE_CYCLES (4),
        .LONG_CYCLES   (10)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_PRESS: return "press";
            K_REL:   return "release";
            default: return "long";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input int c);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long};
    endfunction

    // Monitor: every strobe the DUT presents must match the head of the scoreboard.
    always @(negedge clk) begin
        int   n;
        int   kind;
        exp_t e;
        n = int'(bus.btn_press) + int'(bus.btn_release) + int'(bus.btn_long);
        if (n > 0) begin
            checks++;
            if (n > 1) begin
                failures++;
                $display("FAIL strobe_excl at edge %0d: press=%b release=%b long=%b, expected at most one",
                         cyc, bus.btn_press, bus.btn_release, bus.btn_long);
            end else begin
                kind = bus.btn_press ? K_PRESS : (bus.btn_release ? K_REL : K_LONG);
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe: got %s at edge %0d, expected none", kname(kind), cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.kind != kind || e.cyc != cyc) begin
                        failures++;
                        $display("FAIL strobe: got %s at edge %0d, expected %s at edge %0d",
                                 kname(kind), cyc, kname(e.kind), e.cyc);
                    end
                end
            end
        end
    end

    // Button high for h sampling edges starting after the current edge, then released.
    task automatic hold_press(input string name, input int h);
        int e;
        e = cyc;
        bus.btn_in = 1'b1;
        if (h >= 4) begin
            expect_ev(K_PRESS, e + 6);
            if (h >= 14) expect_ev(K_LONG, e + 16);
            expect_ev(K_REL, e + h + 6);
        end
        step(h);
        chk({name, "_level_held"}, {3'b000, bus.btn_level}, {3'b000, (h >= 6) ? 1'b1 : 1'b0});
        bus.btn_in = 1'b0;
        step(10);
        chk({name, "_level_after"}, {3'b000, bus.btn_level}, 4'b0000);
    endtask

    initial begin
        int e;
        logic [4:0] bounce;

        // 1: reset with button held, then fresh press after reset release
        rst_n      = 1'b0;
        bus.btn_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("reset_outputs", outs(), 4'b0000);
        end
        rst_n = 1'b1;
        e = cyc;
        expect_ev(K_PRESS, e + 6);
        expect_ev(K_REL, e + 12);
        step(6);
        chk("rst_release_level", {3'b000, bus.btn_level}, 4'b0001);
        bus.btn_in = 1'b0;
        step(12);
        chk("rst_release_idle", outs(), 4'b0000);

        // 2: clean press with long-press
        hold_press("clean", 20);

        // 3: bounce before settling high
        e = cyc;
        bounce = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            bus.btn_in = bounce[i];
            step(1);
        end
        expect_ev(K_PRESS, e + 11);
        expect_ev(K_REL, e + 19);
        bus.btn_in = 1'b1;
        step(8);
        chk("bounce_level", {3'b000, bus.btn_level}, 4'b0001);
        bus.btn_in = 1'b0;
        step(10);
        chk("bounce_idle", outs(), 4'b0000);

        // 4: glitch shorter than the check window
        hold_press("glitch", 3);

        // 5: release bounce during long count restarts the long window
        e = cyc;
        bus.btn_in = 1'b1;
        expect_ev(K_PRESS, e + 6);
        expect_ev(K_LONG, e + 27);
        expect_ev(K_REL, e + 41);
        step(12);
        bus.btn_in = 1'b0;
        step(2);
        bus.btn_in = 1'b1;
        step(4);
        chk("relbounce_level", {3'b000, bus.btn_level}, 4'b0001);
        step(17);
        bus.btn_in = 1'b0;
        step(10);
        chk("relbounce_idle", outs(), 4'b0000);

        // 6: reset during CHK_HI at cnt=3 suppresses the pending press
        bus.btn_in = 1'b1;
        step(5);
        rst_n      = 1'b0;
        bus.btn_in = 1'b0;
        step(1);
        chk("midcheck_reset_outputs", outs(), 4'b0000);
        rst_n = 1'b1;
        step(12);
        chk("midcheck_idle", outs(), 4'b0000);
        hold_press("after_reset", 8);

        step(5);
        while (sb.size() > 0) begin
            exp_t m;
            m = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_strobe: got nothing by edge %0d, expected %s at edge %0d",
                     cyc, kname(m.kind), m.cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Conditions one raw mechanical push-button for the lab designs. Synchronises the asynchronous pin into `clk` and filters contact bounce with a stability counter. Emits a clean level plus single-cycle press, release and long-press strobes. Sits directly upstream of the pulse-driven `toggle` stage: `btn_press` drives its `sig` input.

## Interface
- `STABLE_CYCLES`, default 16: consecutive cycles the synchronised input must differ from `btn_level` before `btn_level` flips. Board builds use 500000 (5 ms at 100 MHz). Legal range is 2 or more.
- `LONG_CYCLES`, default 64: cycles `btn_level` must stay high before `btn_long` fires. Must be greater than `STABLE_CYCLES`.
- `CNT_W`, default `$clog2(LONG_CYCLES+1)`: width of the shared counter.
- `clk` in 1: single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `btn_in` in 1: raw pin, asynchronous, active-high.
- `btn_level` out 1: debounced button state.
- `btn_press` out 1: one-cycle strobe on the debounced rising edge.
- `btn_release` out 1: one-cycle strobe on the debounced falling edge.
- `btn_long` out 1: one-cycle strobe, at most once per press, after `btn_level` has been high for `LONG_CYCLES` cycles.

## Operation
- **Synchroniser:** two-flop synchroniser `sync1 -> sync2`. Only `sync2` is used downstream.
- **State machine and counter:** FSM states are `S_LO`, `CHK_HI`, `S_HI` and `CHK_LO`. One counter `cnt`, `CNT_W` bits wide.
- **`S_LO`:**
  - `cnt` = 0.
  - `sync2` = 1 -> go to `CHK_HI` with `cnt` = 1.
- **`CHK_HI`:**
  - `sync2` = 0 (bounce) -> go to `S_LO` and clear `cnt`.
  - Else, if `cnt` = `STABLE_CYCLES`-1 -> go to `S_HI`, set `cnt` = 0, assert `btn_press` for the next cycle.
  - Else `cnt`++.
- **`S_HI`:**
  - `sync2` = 0 -> go to `CHK_LO` with `cnt` = 1. The long-press count is abandoned.
  - Else `cnt` counts up, saturating at `LONG_CYCLES`.
  - When `cnt` reaches `LONG_CYCLES`-1 with `sync2` = 1, assert `btn_long` for the next cycle.
  - Saturation guarantees only one `btn_long` per press.
- **`CHK_LO`:** mirror of `CHK_HI`.
  - `sync2` = 1 -> return to `S_HI` with `cnt` = 0. The long-press count restarts; a fresh `btn_long` is allowed.
  - Stable for the full window -> go to `S_LO`, assert `btn_release` for the next cycle.
- **`btn_level`:** 1 exactly in `S_HI` and `CHK_LO`.
- **Registered outputs:** all outputs are registered; there is no combinational path from `btn_in`.
- **Mutual exclusion:** `btn_press`, `btn_release` and `btn_long` are never high in the same cycle.
- **Counter range:** the counter never wraps and never exceeds `LONG_CYCLES`.

## Timing
- **Reset:** with `rst_n` = 0 at a rising edge:
  - `sync1`, `sync2` = 0.
  - FSM = `S_LO`, `cnt` = 0.
  - `btn_level`, `btn_press`, `btn_release`, `btn_long` all = 0.
- **Reset mid-operation:** reset aborts any check or long count. No strobe is emitted in the cycle after a reset edge.
- **Button held at reset release:** a button held through reset release is treated as a fresh press and yields `btn_press` after the full latency.
- **Press latency:** `btn_in` first sampled high at edge k gives `sync2` = 1 after k+1. `btn_level` and `btn_press` go high after edge k+1+`STABLE_CYCLES`. `btn_press` drops after the next edge.
- **Release latency:** symmetric to press latency.
- **Long-press timing:** `btn_long` goes high `LONG_CYCLES` edges after `btn_level` rose, provided `sync2` stayed high throughout.
- **Bounce rejection:** any single-cycle glitch of `sync2` during a check window restarts the window. Pulses shorter than `STABLE_CYCLES` produce no output change.

## Structure
- **Package `btn_pkg`:** holds the FSM state typedef (2-bit encoding: `S_LO`=0, `CHK_HI`=1, `S_HI`=2, `CHK_LO`=3) and the parameter legality rules used by the assertions.
- **Sub-module `sync_2ff`:** the synchroniser, instantiated once. It is reset by the same `rst_n`.
- **Everything else** lives in one always block plus next-state logic in the top.

## Test plan
All scenarios use `STABLE_CYCLES`=4 and `LONG_CYCLES`=10.
1. **Reset:** hold `rst_n` = 0 for 3 cycles with `btn_in` = 1 -> all outputs 0 during reset. After release, `btn_press` pulses exactly once, 5 edges after the first sampling edge.
2. **Clean press and release:** `btn_in` high for 20 cycles, then low -> `btn_level` high for 20 cycles, one `btn_press`, one `btn_release`. `btn_long` fires 10 cycles after `btn_press`.
3. **Bounce:** `btn_in` pattern 1,0,1,1,0,1,1,1,1,1… -> a single `btn_press`, emitted 4 edges after the last 0 leaves `sync2`. No `btn_release`.
4. **Short glitch:** `btn_in` high for 3 cycles -> no outputs change.
5. **Release bounce during long count:** held 8 cycles after `btn_press`, a 2-cycle low, then high -> no `btn_release`. `btn_long` fires 10 cycles after the return high, exactly once.
6. **Reset mid-check:** `rst_n` = 0 for 1 cycle during `CHK_HI` at `cnt`=3 -> no `btn_press` follows reset. The check restarts from `S_LO`.
